// File: rtl/seg7_scan_display.sv
// Multiplexed hex seven-segment scanner: a prescaler paces a digit index,
// new values are double-buffered and swapped only at frame boundaries.
// Ports: clk, rst_n (sync, active-low), enable, load, value_in, dp_in,
//        lz_blank in; seg {g..a}, dp, digit_en (one-hot), pending out.
module seg7_scan_display #(
  parameter int NUM_DIGITS     = 4,
  parameter int PRESCALE       = 1024,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    pending
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;

  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);
  localparam logic          INV       = (SEG_ACTIVE_LOW != 0);

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0] shdp_q, shdp_d;
  logic [VW-1:0]         disp_q, disp_d;
  logic [NUM_DIGITS-1:0] dispdp_q, dispdp_d;
  logic                  pending_q, pending_d;

  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;

  logic tick;
  logic boundary;

  assign tick     = enable && (presc_q == PRESC_MAX);
  assign boundary = tick && (idx_q == LAST_IDX);

  // Scan timing
  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    if (enable) begin
      if (tick) begin
        presc_d = '0;
        if (idx_q == LAST_IDX) idx_d = '0;
        else                   idx_d = idx_q + IW'(1);
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // Double buffer: a load on the boundary itself
  // bypasses the shadow and leaves nothing pending.
  always_comb begin
    shadow_d  = shadow_q;
    shdp_d    = shdp_q;
    disp_d    = disp_q;
    dispdp_d  = dispdp_q;
    pending_d = pending_q;
    if (load) begin
      shadow_d = value_in;
      shdp_d   = dp_in;
    end
    if (boundary) begin
      pending_d = 1'b0;
      if (load) begin
        disp_d   = value_in;
        dispdp_d = dp_in;
      end else if (pending_q) begin
        disp_d   = shadow_q;
        dispdp_d = shdp_q;
      end
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

  // hi_nz[k]: nibble k or any higher nibble is nonzero
  logic [NUM_DIGITS-1:0] hi_nz;
  always_comb begin
    hi_nz = '0;
    hi_nz[NUM_DIGITS-1] = |disp_q[VW-1 -: 4];
    for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
      hi_nz[k] = hi_nz[k+1] | (|disp_q[4*k +: 4]);
    end
  end

  logic [3:0] nib;
  logic       dp_sel;
  logic       blank;
  always_comb begin
    nib    = '0;
    dp_sel = 1'b0;
    blank  = 1'b0;
    en_d   = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        nib     = disp_q[4*k +: 4];
        dp_sel  = dispdp_q[k];
        blank   = lz_blank && (k != 0) && !hi_nz[k];
        en_d[k] = 1'b1;
      end
    end
    if (!enable) en_d = '0;
  end

  logic [6:0] hex;
  always_comb begin
    hex = 7'h00;
    unique case (nib)
      4'h0: hex = 7'h3F;
      4'h1: hex = 7'h06;
      4'h2: hex = 7'h5B;
      4'h3: hex = 7'h4F;
      4'h4: hex = 7'h66;
      4'h5: hex = 7'h6D;
      4'h6: hex = 7'h7D;
      4'h7: hex = 7'h07;
      4'h8: hex = 7'h7F;
      4'h9: hex = 7'h6F;
      4'hA: hex = 7'h77;
      4'hB: hex = 7'h7C;
      4'hC: hex = 7'h39;
      4'hD: hex = 7'h5E;
      4'hE: hex = 7'h79;
      4'hF: hex = 7'h71;
    endcase
  end

  always_comb begin
    seg_d = '0;
    dp_d  = 1'b0;
    if (enable) begin
      seg_d = blank ? 7'h00 : hex;
      dp_d  = dp_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q   <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      shdp_q    <= '0;
      disp_q    <= '0;
      dispdp_q  <= '0;
      pending_q <= 1'b0;
      seg_q     <= '0;
      dp_q      <= 1'b0;
      en_q      <= '0;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      shdp_q    <= shdp_d;
      disp_q    <= disp_d;
      dispdp_q  <= dispdp_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      en_q      <= en_d;
    end
  end

  // Internal registers are active-high; polarity applies only at the pins.
  assign seg      = seg_q ^ {7{INV}};
  assign dp       = dp_q ^ INV;
  assign digit_en = en_q ^ {NUM_DIGITS{INV}};
  assign pending  = pending_q;

endmodule
